// File: rtl/bp_me_cache_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_cache_bank_router
// Brief    : Steers CCE memory commands to address-selected cache banks with
//            in-order response return, and round-robin merges bank memory
//            traffic onto one memory port. Optional macro
//            BP_ME_CACHE_BANK_XOR_HASH_EN enables XOR-hashed bank select.
// Revision : 1.0 - initial multi-bank release
// ============================================================================

module bp_me_cache_bank_router_fifo #(
    parameter int width_p = 2,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [cnt_w_lp-1:0] count;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Callers never push when full nor pop when empty.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_i && !pop_i)
                count <= count + 1'b1;
            else if (!push_i && pop_i)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (count == cnt_w_lp'(els_p));
    assign empty_o = (count == '0);
endmodule

module bp_me_cache_bank_router #(
    parameter int num_banks_p      = 4,
    parameter int msg_width_p      = 512,
    parameter int addr_lsb_p       = 64,
    parameter int bank_sel_lsb_p   = 6,
    parameter int up_outstanding_p = 8,
    parameter int dn_outstanding_p = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,

    input  logic [msg_width_p-1:0]             mem_cmd_i,
    input  logic                               mem_cmd_v_i,
    output logic                               mem_cmd_ready_o,
    output logic [msg_width_p-1:0]             mem_resp_o,
    output logic                               mem_resp_v_o,
    input  logic                               mem_resp_yumi_i,

    output logic [num_banks_p*msg_width_p-1:0] bank_cmd_o,
    output logic [num_banks_p-1:0]             bank_cmd_v_o,
    input  logic [num_banks_p-1:0]             bank_cmd_ready_i,
    input  logic [num_banks_p*msg_width_p-1:0] bank_resp_i,
    input  logic [num_banks_p-1:0]             bank_resp_v_i,
    output logic [num_banks_p-1:0]             bank_resp_yumi_o,

    input  logic [num_banks_p*msg_width_p-1:0] bank_mem_cmd_i,
    input  logic [num_banks_p-1:0]             bank_mem_cmd_v_i,
    output logic [num_banks_p-1:0]             bank_mem_cmd_yumi_o,
    output logic [num_banks_p*msg_width_p-1:0] bank_mem_resp_o,
    output logic [num_banks_p-1:0]             bank_mem_resp_v_o,
    input  logic [num_banks_p-1:0]             bank_mem_resp_ready_i,

    output logic [msg_width_p-1:0]             mem_cmd_o,
    output logic                               mem_cmd_v_o,
    input  logic                               mem_cmd_yumi_i,
    input  logic [msg_width_p-1:0]             mem_resp_i,
    input  logic                               mem_resp_v_i,
    output logic                               mem_resp_ready_o
);
    localparam int lg_banks_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
    localparam int sel_bit_lp  = addr_lsb_p + bank_sel_lsb_p;

    logic [lg_banks_lp-1:0] sel;
    logic [lg_banks_lp-1:0] up_head;
    logic                   up_full;
    logic                   up_empty;
    logic                   up_push;
    logic                   up_pop;

    logic [lg_banks_lp-1:0] dn_head;
    logic                   dn_full;
    logic                   dn_empty;
    logic                   dn_push;
    logic                   dn_pop;

    logic [lg_banks_lp-1:0] rr_ptr;
    logic [lg_banks_lp-1:0] rr_next;
    logic [lg_banks_lp-1:0] grant;
    logic [lg_banks_lp-1:0] cand;
    logic                   found;

    // ------------------------------------------------------------------
    // Bank select
    // ------------------------------------------------------------------
    generate
        if (num_banks_p == 1) begin : g_single_bank
            assign sel = '0;
        end else begin : g_multi_bank
`ifdef BP_ME_CACHE_BANK_XOR_HASH_EN
            assign sel = mem_cmd_i[sel_bit_lp +: lg_banks_lp]
                       ^ mem_cmd_i[sel_bit_lp + lg_banks_lp +: lg_banks_lp];
`else
            assign sel = mem_cmd_i[sel_bit_lp +: lg_banks_lp];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Upstream: issue to selected bank, return responses in issue order
    // ------------------------------------------------------------------
    assign bank_cmd_o = {num_banks_p{mem_cmd_i}};

    always_comb begin
        bank_cmd_v_o      = '0;
        bank_cmd_v_o[sel] = mem_cmd_v_i & ~up_full;
        mem_cmd_ready_o   = bank_cmd_ready_i[sel] & ~up_full;
        mem_resp_v_o      = ~up_empty & bank_resp_v_i[up_head];
        mem_resp_o        = bank_resp_i[up_head*msg_width_p +: msg_width_p];
    end

    assign up_push = mem_cmd_v_i & mem_cmd_ready_o;
    assign up_pop  = mem_resp_yumi_i & ~up_empty & bank_resp_v_i[up_head];

    always_comb begin
        bank_resp_yumi_o          = '0;
        bank_resp_yumi_o[up_head] = up_pop;
    end

    bp_me_cache_bank_router_fifo #(
        .width_p (lg_banks_lp),
        .els_p   (up_outstanding_p)
    ) up_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (up_push),
        .data_i  (sel),
        .pop_i   (up_pop),
        .data_o  (up_head),
        .full_o  (up_full),
        .empty_o (up_empty)
    );

    // ------------------------------------------------------------------
    // Downstream: round-robin merge of bank memory commands
    // ------------------------------------------------------------------
    // Index arithmetic wraps naturally because num_banks_p == 2**lg_banks_lp.
    always_comb begin
        grant = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < num_banks_p; i++) begin
            cand = rr_ptr + lg_banks_lp'(i);
            if (!found && bank_mem_cmd_v_i[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign rr_next     = (num_banks_p == 1) ? '0 : grant + 1'b1;
    assign mem_cmd_v_o = (|bank_mem_cmd_v_i) & ~dn_full;
    assign mem_cmd_o   = bank_mem_cmd_i[grant*msg_width_p +: msg_width_p];
    assign dn_push     = mem_cmd_yumi_i & mem_cmd_v_o;

    always_comb begin
        bank_mem_cmd_yumi_o        = '0;
        bank_mem_cmd_yumi_o[grant] = dn_push;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            rr_ptr <= '0;
        else if (dn_push)
            rr_ptr <= rr_next;
    end

    assign bank_mem_resp_o  = {num_banks_p{mem_resp_i}};
    assign mem_resp_ready_o = ~dn_empty & bank_mem_resp_ready_i[dn_head];
    assign dn_pop           = mem_resp_v_i & mem_resp_ready_o;

    always_comb begin
        bank_mem_resp_v_o          = '0;
        bank_mem_resp_v_o[dn_head] = mem_resp_v_i & ~dn_empty;
    end

    bp_me_cache_bank_router_fifo #(
        .width_p (lg_banks_lp),
        .els_p   (dn_outstanding_p)
    ) dn_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (dn_push),
        .data_i  (grant),
        .pop_i   (dn_pop),
        .data_o  (dn_head),
        .full_o  (dn_full),
        .empty_o (dn_empty)
    );

    // Consuming a response that is not being offered is a protocol error.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_resp_yumi_i && !mem_resp_v_o));
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bp_me_cache_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_cache_bank_router
// Brief    : Directed self-checking bench for bp_me_cache_bank_router.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_me_cache_bank_router;
    localparam int N = 4;
    localparam int W = 512;

    logic clk;
    logic reset;
    logic [W-1:0]   mem_cmd_i;
    logic           mem_cmd_v_i;
    logic           mem_cmd_ready_o;
    logic [W-1:0]   mem_resp_o;
    logic           mem_resp_v_o;
    logic           mem_resp_yumi_i;
    logic [N*W-1:0] bank_cmd_o;
    logic [N-1:0]   bank_cmd_v_o;
    logic [N-1:0]   bank_cmd_ready_i;
    logic [N*W-1:0] bank_resp_i;
    logic [N-1:0]   bank_resp_v_i;
    logic [N-1:0]   bank_resp_yumi_o;
    logic [N*W-1:0] bank_mem_cmd_i;
    logic [N-1:0]   bank_mem_cmd_v_i;
    logic [N-1:0]   bank_mem_cmd_yumi_o;
    logic [N*W-1:0] bank_mem_resp_o;
    logic [N-1:0]   bank_mem_resp_v_o;
    logic [N-1:0]   bank_mem_resp_ready_i;
    logic [W-1:0]   mem_cmd_o;
    logic           mem_cmd_v_o;
    logic           mem_cmd_yumi_i;
    logic [W-1:0]   mem_resp_i;
    logic           mem_resp_v_i;
    logic           mem_resp_ready_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    bp_me_cache_bank_router #(
        .num_banks_p      (N),
        .msg_width_p      (W),
        .addr_lsb_p       (64),
        .bank_sel_lsb_p   (6),
        .up_outstanding_p (8),
        .dn_outstanding_p (8)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .mem_cmd_i             (mem_cmd_i),
        .mem_cmd_v_i           (mem_cmd_v_i),
        .mem_cmd_ready_o       (mem_cmd_ready_o),
        .mem_resp_o            (mem_resp_o),
        .mem_resp_v_o          (mem_resp_v_o),
        .mem_resp_yumi_i       (mem_resp_yumi_i),
        .bank_cmd_o            (bank_cmd_o),
        .bank_cmd_v_o          (bank_cmd_v_o),
        .bank_cmd_ready_i      (bank_cmd_ready_i),
        .bank_resp_i           (bank_resp_i),
        .bank_resp_v_i         (bank_resp_v_i),
        .bank_resp_yumi_o      (bank_resp_yumi_o),
        .bank_mem_cmd_i        (bank_mem_cmd_i),
        .bank_mem_cmd_v_i      (bank_mem_cmd_v_i),
        .bank_mem_cmd_yumi_o   (bank_mem_cmd_yumi_o),
        .bank_mem_resp_o       (bank_mem_resp_o),
        .bank_mem_resp_v_o     (bank_mem_resp_v_o),
        .bank_mem_resp_ready_i (bank_mem_resp_ready_i),
        .mem_cmd_o             (mem_cmd_o),
        .mem_cmd_v_o           (mem_cmd_v_o),
        .mem_cmd_yumi_i        (mem_cmd_yumi_i),
        .mem_resp_i            (mem_resp_i),
        .mem_resp_v_i          (mem_resp_v_i),
        .mem_resp_ready_o      (mem_resp_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [39:0] paddr, input logic [15:0] tag);
        logic [W-1:0] m;
        m = '0;
        m[64 +: 40] = paddr;
        m[15:0] = tag;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (mem_resp_v_o !== 1'b0) $display("FAIL reset_resp_v: got %b expected 0", mem_resp_v_o); else pass_cnt++;
        total_cnt++; if (mem_cmd_v_o !== 1'b0) $display("FAIL reset_mem_cmd_v: got %b expected 0", mem_cmd_v_o); else pass_cnt++;
        total_cnt++; if (bank_cmd_v_o !== 4'b0000) $display("FAIL reset_bank_cmd_v: got %b expected 0000", bank_cmd_v_o); else pass_cnt++;
        total_cnt++; if (mem_resp_ready_o !== 1'b0) $display("FAIL reset_mem_resp_ready: got %b expected 0", mem_resp_ready_o); else pass_cnt++;
        total_cnt++; if (bank_mem_resp_v_o !== 4'b0000) $display("FAIL reset_bank_mem_resp_v: got %b expected 0000", bank_mem_resp_v_o); else pass_cnt++;
        total_cnt++; if (bank_resp_yumi_o !== 4'b0000) $display("FAIL reset_bank_resp_yumi: got %b expected 0000", bank_resp_yumi_o); else pass_cnt++;
        total_cnt++; if (bank_mem_cmd_yumi_o !== 4'b0000) $display("FAIL reset_bank_mem_cmd_yumi: got %b expected 0000", bank_mem_cmd_yumi_o); else pass_cnt++;
        total_cnt++; if (mem_cmd_ready_o !== 1'b1) $display("FAIL reset_mem_cmd_ready: got %b expected 1", mem_cmd_ready_o); else pass_cnt++;
        step();
    endtask

    task automatic test_bank_select();
        logic [39:0] addrs [4];
        logic [N-1:0] exp;
        addrs[0] = 40'h000; addrs[1] = 40'h040; addrs[2] = 40'h080; addrs[3] = 40'h0C0;
        for (int i = 0; i < 4; i++) begin
            mem_cmd_i = mk(addrs[i], 16'h0010 + 16'(i));
            mem_cmd_v_i = 1'b1;
            exp = 4'b0001 << i;
            #1;
            total_cnt++; if (bank_cmd_v_o !== exp) $display("FAIL sel_onehot[%0d]: got %b expected %b", i, bank_cmd_v_o, exp); else pass_cnt++;
            total_cnt++; if (bank_cmd_o[i*W +: W] !== mem_cmd_i) $display("FAIL sel_bcast[%0d]: got %h expected %h", i, bank_cmd_o[i*W +: 64], mem_cmd_i[63:0]); else pass_cnt++;
            step();
        end
        mem_cmd_v_i = 1'b0;
        for (int j = 0; j < N; j++) bank_resp_i[j*W +: W] = mk(40'h0, 16'h0100 + 16'(j));
        bank_resp_v_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            mem_resp_yumi_i = 1'b1;
            exp = 4'b0001 << i;
            #1;
            total_cnt++; if (mem_resp_o !== mk(40'h0, 16'h0100 + 16'(i))) $display("FAIL sel_resp_data[%0d]: got %h expected %h", i, mem_resp_o[15:0], 16'h0100 + 16'(i)); else pass_cnt++;
            total_cnt++; if (bank_resp_yumi_o !== exp) $display("FAIL sel_resp_yumi[%0d]: got %b expected %b", i, bank_resp_yumi_o, exp); else pass_cnt++;
            step();
        end
        mem_resp_yumi_i = 1'b0;
        #1;
        total_cnt++; if (mem_resp_v_o !== 1'b0) $display("FAIL sel_drained: got %b expected 0", mem_resp_v_o); else pass_cnt++;
        bank_resp_v_i = 4'b0000;
        step();
    endtask

    task automatic test_in_order();
        mem_cmd_v_i = 1'b1;
        mem_cmd_i = mk(40'h040, 16'h0021);
        step();
        mem_cmd_i = mk(40'h000, 16'h0020);
        step();
        mem_cmd_v_i = 1'b0;
        bank_resp_i[0*W +: W] = mk(40'h0, 16'h00A0);
        bank_resp_i[1*W +: W] = mk(40'h0, 16'h00A1);
        bank_resp_v_i = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            #1;
            total_cnt++; if (mem_resp_v_o !== 1'b0) $display("FAIL order_stall_v[%0d]: got %b expected 0", k, mem_resp_v_o); else pass_cnt++;
            total_cnt++; if (bank_resp_yumi_o !== 4'b0000) $display("FAIL order_stall_yumi[%0d]: got %b expected 0000", k, bank_resp_yumi_o); else pass_cnt++;
            step();
        end
        bank_resp_v_i = 4'b0011;
        mem_resp_yumi_i = 1'b1;
        #1;
        total_cnt++; if (mem_resp_o !== mk(40'h0, 16'h00A1)) $display("FAIL order_first: got %h expected 00a1", mem_resp_o[15:0]); else pass_cnt++;
        total_cnt++; if (bank_resp_yumi_o !== 4'b0010) $display("FAIL order_first_yumi: got %b expected 0010", bank_resp_yumi_o); else pass_cnt++;
        step();
        total_cnt++; if (mem_resp_o !== mk(40'h0, 16'h00A0)) $display("FAIL order_second: got %h expected 00a0", mem_resp_o[15:0]); else pass_cnt++;
        total_cnt++; if (bank_resp_yumi_o !== 4'b0001) $display("FAIL order_second_yumi: got %b expected 0001", bank_resp_yumi_o); else pass_cnt++;
        step();
        mem_resp_yumi_i = 1'b0;
        bank_resp_v_i = 4'b0000;
    endtask

    task automatic test_up_full();
        mem_cmd_v_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_cmd_i = mk(40'(i * 'h40), 16'h0030 + 16'(i));
            step();
        end
        mem_cmd_i = mk(40'h000, 16'h0038);
        #1;
        total_cnt++; if (mem_cmd_ready_o !== 1'b0) $display("FAIL full_ready: got %b expected 0", mem_cmd_ready_o); else pass_cnt++;
        total_cnt++; if (bank_cmd_v_o !== 4'b0000) $display("FAIL full_bank_v: got %b expected 0000", bank_cmd_v_o); else pass_cnt++;
        bank_resp_i[0*W +: W] = mk(40'h0, 16'h00B0);
        bank_resp_v_i = 4'b0001;
        mem_resp_yumi_i = 1'b1;
        #1;
        total_cnt++; if (mem_resp_v_o !== 1'b1) $display("FAIL full_resp_v: got %b expected 1", mem_resp_v_o); else pass_cnt++;
        total_cnt++; if (mem_cmd_ready_o !== 1'b0) $display("FAIL full_pop_cycle_ready: got %b expected 0", mem_cmd_ready_o); else pass_cnt++;
        step();
        mem_resp_yumi_i = 1'b0;
        bank_resp_v_i = 4'b0000;
        #1;
        total_cnt++; if (mem_cmd_ready_o !== 1'b1) $display("FAIL full_after_pop_ready: got %b expected 1", mem_cmd_ready_o); else pass_cnt++;
        total_cnt++; if (bank_cmd_v_o !== 4'b0001) $display("FAIL full_after_pop_bank_v: got %b expected 0001", bank_cmd_v_o); else pass_cnt++;
        mem_cmd_v_i = 1'b0;
        bank_resp_v_i = 4'b1111;
        mem_resp_yumi_i = 1'b1;
        repeat (7) step();
        mem_resp_yumi_i = 1'b0;
        #1;
        total_cnt++; if (mem_resp_v_o !== 1'b0) $display("FAIL full_drained: got %b expected 0", mem_resp_v_o); else pass_cnt++;
        bank_resp_v_i = 4'b0000;
        step();
    endtask

    task automatic test_rr();
        logic [N-1:0] exp;
        int g;
        for (int j = 0; j < N; j++) bank_mem_cmd_i[j*W +: W] = mk(40'h0, 16'h0200 + 16'(j));
        bank_mem_cmd_v_i = 4'b1111;
        mem_cmd_yumi_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            exp = 4'b0001 << g;
            #1;
            total_cnt++; if (mem_cmd_o !== mk(40'h0, 16'h0200 + 16'(g))) $display("FAIL rr_grant[%0d]: got %h expected %h", k, mem_cmd_o[15:0], 16'h0200 + 16'(g)); else pass_cnt++;
            total_cnt++; if (bank_mem_cmd_yumi_o !== exp) $display("FAIL rr_yumi[%0d]: got %b expected %b", k, bank_mem_cmd_yumi_o, exp); else pass_cnt++;
            step();
        end
        bank_mem_cmd_v_i = 4'b0000;
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            exp = 4'b0001 << g;
            mem_resp_i = mk(40'h0, 16'h0300 + 16'(k));
            #1;
            total_cnt++; if (bank_mem_resp_v_o !== exp) $display("FAIL rr_resp_v[%0d]: got %b expected %b", k, bank_mem_resp_v_o, exp); else pass_cnt++;
            total_cnt++; if (mem_resp_ready_o !== 1'b1) $display("FAIL rr_resp_ready[%0d]: got %b expected 1", k, mem_resp_ready_o); else pass_cnt++;
            total_cnt++; if (bank_mem_resp_o[g*W +: W] !== mk(40'h0, 16'h0300 + 16'(k))) $display("FAIL rr_resp_data[%0d]: got %h expected %h", k, bank_mem_resp_o[g*W +: 16], 16'h0300 + 16'(k)); else pass_cnt++;
            step();
        end
        #1;
        total_cnt++; if (mem_resp_ready_o !== 1'b0) $display("FAIL rr_resp_empty: got %b expected 0", mem_resp_ready_o); else pass_cnt++;
        total_cnt++; if (bank_mem_resp_v_o !== 4'b0000) $display("FAIL rr_resp_empty_v: got %b expected 0000", bank_mem_resp_v_o); else pass_cnt++;
        mem_resp_v_i = 1'b0;
        step();
    endtask

    task automatic test_dn_backpressure();
        bank_mem_cmd_v_i = 4'b0100;
        mem_cmd_yumi_i = 1'b1;
        #1;
        total_cnt++; if (bank_mem_cmd_yumi_o !== 4'b0100) $display("FAIL bp_cmd_yumi: got %b expected 0100", bank_mem_cmd_yumi_o); else pass_cnt++;
        step();
        bank_mem_cmd_v_i = 4'b0000;
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i = 1'b1;
        mem_resp_i = mk(40'h0, 16'h0400);
        bank_mem_resp_ready_i = 4'b1011;
        #1;
        total_cnt++; if (mem_resp_ready_o !== 1'b0) $display("FAIL bp_blocked_ready: got %b expected 0", mem_resp_ready_o); else pass_cnt++;
        total_cnt++; if (bank_mem_resp_v_o !== 4'b0100) $display("FAIL bp_blocked_v: got %b expected 0100", bank_mem_resp_v_o); else pass_cnt++;
        step();
        total_cnt++; if (bank_mem_resp_v_o !== 4'b0100) $display("FAIL bp_held_v: got %b expected 0100", bank_mem_resp_v_o); else pass_cnt++;
        bank_mem_resp_ready_i = 4'b1111;
        #1;
        total_cnt++; if (mem_resp_ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", mem_resp_ready_o); else pass_cnt++;
        step();
        total_cnt++; if (mem_resp_ready_o !== 1'b0) $display("FAIL bp_popped: got %b expected 0", mem_resp_ready_o); else pass_cnt++;
        mem_resp_v_i = 1'b0;
        step();
    endtask

    task automatic test_hash();
        logic [N-1:0] exp_100;
        logic [N-1:0] exp_140;
`ifdef BP_ME_CACHE_BANK_XOR_HASH_EN
        exp_100 = 4'b0010;
        exp_140 = 4'b0001;
`else
        exp_100 = 4'b0001;
        exp_140 = 4'b0010;
`endif
        mem_cmd_i = mk(40'h140, 16'h0051);
        mem_cmd_v_i = 1'b1;
        #1;
        total_cnt++; if (bank_cmd_v_o !== exp_140) $display("FAIL hash_140: got %b expected %b", bank_cmd_v_o, exp_140); else pass_cnt++;
        mem_cmd_i = mk(40'h100, 16'h0050);
        #1;
        total_cnt++; if (bank_cmd_v_o !== exp_100) $display("FAIL hash_100: got %b expected %b", bank_cmd_v_o, exp_100); else pass_cnt++;
        step();
        mem_cmd_v_i = 1'b0;
        bank_resp_v_i = 4'b1111;
        mem_resp_yumi_i = 1'b1;
        #1;
        total_cnt++; if (bank_resp_yumi_o !== exp_100) $display("FAIL hash_resp_yumi: got %b expected %b", bank_resp_yumi_o, exp_100); else pass_cnt++;
        step();
        mem_resp_yumi_i = 1'b0;
        bank_resp_v_i = 4'b0000;
    endtask

    task automatic test_reset_mid();
        mem_cmd_v_i = 1'b1;
        mem_cmd_i = mk(40'h040, 16'h0060);
        step();
        mem_cmd_i = mk(40'h080, 16'h0061);
        step();
        mem_cmd_v_i = 1'b0;
        bank_mem_cmd_v_i = 4'b0010;
        mem_cmd_yumi_i = 1'b1;
        step();
        bank_mem_cmd_v_i = 4'b0000;
        mem_cmd_yumi_i = 1'b0;
        reset = 1'b1;
        bank_resp_v_i = 4'b1111;
        mem_resp_v_i = 1'b1;
        step();
        total_cnt++; if (mem_resp_v_o !== 1'b0) $display("FAIL rst_mid_resp_v: got %b expected 0", mem_resp_v_o); else pass_cnt++;
        total_cnt++; if (bank_mem_resp_v_o !== 4'b0000) $display("FAIL rst_mid_bank_mem_resp_v: got %b expected 0000", bank_mem_resp_v_o); else pass_cnt++;
        total_cnt++; if (mem_resp_ready_o !== 1'b0) $display("FAIL rst_mid_mem_resp_ready: got %b expected 0", mem_resp_ready_o); else pass_cnt++;
        total_cnt++; if (mem_cmd_v_o !== 1'b0) $display("FAIL rst_mid_mem_cmd_v: got %b expected 0", mem_cmd_v_o); else pass_cnt++;
        total_cnt++; if (bank_cmd_v_o !== 4'b0000) $display("FAIL rst_mid_bank_cmd_v: got %b expected 0000", bank_cmd_v_o); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (mem_resp_v_o !== 1'b0) $display("FAIL rst_mid_up_empty: got %b expected 0", mem_resp_v_o); else pass_cnt++;
        bank_mem_cmd_v_i = 4'b1111;
        #1;
        total_cnt++; if (mem_cmd_o !== mk(40'h0, 16'h0200)) $display("FAIL rst_mid_rr_ptr: got %h expected 0200", mem_cmd_o[15:0]); else pass_cnt++;
        bank_mem_cmd_v_i = 4'b0000;
        bank_resp_v_i = 4'b0000;
        mem_resp_v_i = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        mem_cmd_i = '0;
        mem_cmd_v_i = 1'b0;
        mem_resp_yumi_i = 1'b0;
        bank_cmd_ready_i = 4'b1111;
        bank_resp_i = '0;
        bank_resp_v_i = 4'b0000;
        bank_mem_cmd_i = '0;
        bank_mem_cmd_v_i = 4'b0000;
        bank_mem_resp_ready_i = 4'b1111;
        mem_cmd_yumi_i = 1'b0;
        mem_resp_i = '0;
        mem_resp_v_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_bank_select();
        test_in_order();
        test_up_full();
        test_rr();
        test_dn_backpressure();
        test_hash();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
